// File: rtl/uart_tx_fifo_if.sv
// Producer/UART handshake bundle for uart_tx_fifo.
// slave  : the FIFO itself.
// master : the environment around it (MMIO producer plus uart_tx).
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              timeout_err;
  logic              clr_err;
  logic              uart_busy;
  logic              uart_write_en;
  logic [7:0]        uart_data;

  modport slave (
    input  wr_en, wr_data, clr_err, uart_busy,
    output full, empty, count, overflow, timeout_err, uart_write_en, uart_data
  );

  modport master (
    output wr_en, wr_data, clr_err, uart_busy,
    input  full, empty, count, overflow, timeout_err, uart_write_en, uart_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus drain controller feeding uart_tx.
// Optional feature: define UART_FIFO_CRLF_EN to expand each pushed 0x0A
// into the pair 0x0D,0x0A (second byte written from a pending register).
module uart_tx_fifo #(
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [TW-1:0]   TMAX     = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic [TW-1:0]     timer, timer_nxt;
  state_t            state, state_nxt;
  logic              launch, to_set;
  logic              full_i, empty_i;
  logic              push_ok, ovf_set, do_wr;
  logic [7:0]        wbyte;

  assign empty_i = (cnt == '0);

`ifdef UART_FIFO_CRLF_EN
  localparam logic [ADDR_W:0] CNT_ROOM2 = (ADDR_W+1)'(DEPTH - 2);
  logic pend, is_lf, lf_room;

  assign is_lf   = (bus.wr_data == 8'h0A);
  assign lf_room = (cnt <= CNT_ROOM2);
  // Producer is held off for the cycle the trailing 0x0A is written.
  assign full_i  = (cnt == CNT_FULL) || pend;
  assign push_ok = bus.wr_en && !full_i && (!is_lf || lf_room);
  assign ovf_set = bus.wr_en && !push_ok;
  assign do_wr   = pend || push_ok;
  assign wbyte   = pend ? 8'h0A : (is_lf ? 8'h0D : bus.wr_data);

  // Pending LF: armed when a CR has been written in place of a pushed LF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= 1'b0;
    else     pend <= push_ok && is_lf;
  end
`else
  assign full_i  = (cnt == CNT_FULL);
  assign push_ok = bus.wr_en && !full_i;
  assign ovf_set = bus.wr_en && full_i;
  assign do_wr   = push_ok;
  assign wbyte   = bus.wr_data;
`endif

  assign bus.full  = full_i;
  assign bus.empty = empty_i;
  assign bus.count = cnt;

  // Drain FSM: launch one byte, wait for busy to rise, then to fall.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    launch    = 1'b0;
    to_set    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_i && !bus.uart_busy) begin
          launch    = 1'b1;
          timer_nxt = '0;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (bus.uart_busy) begin
          state_nxt = WAIT_DONE;
        end else if (timer == TMAX) begin
          // uart_tx never acknowledged: drop this byte, do not retry.
          to_set    = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.uart_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wbyte;
  end

  // Pointers, occupancy, FSM state, UART launch register and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      cnt               <= '0;
      state             <= IDLE;
      timer             <= '0;
      bus.uart_write_en <= 1'b0;
      bus.uart_data     <= 8'h00;
      bus.overflow      <= 1'b0;
      bus.timeout_err   <= 1'b0;
    end else begin
      state             <= state_nxt;
      timer             <= timer_nxt;
      bus.uart_write_en <= launch;
      if (do_wr)  wr_ptr <= wr_ptr + ADDR_W'(1);
      if (launch) begin
        rd_ptr        <= rd_ptr + ADDR_W'(1);
        bus.uart_data <= mem[rd_ptr];
      end
      case ({do_wr, launch})
        2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
        2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
        default: cnt <= cnt;
      endcase
      // A new error event beats a same-cycle clear.
      if (ovf_set)          bus.overflow <= 1'b1;
      else if (bus.clr_err) bus.overflow <= 1'b0;
      if (to_set)           bus.timeout_err <= 1'b1;
      else if (bus.clr_err) bus.timeout_err <= 1'b0;
    end
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO plus drain controller between the pc_one MMIO UART store path (producer) and uart_tx (consumer).
- Absorbs bursts of CPU writes, such as hex dumps and string prints, so the core never stalls on uart_busy.
- Serialises bytes into uart_tx using its write_en/data/uart_busy handshake.
- Runs in the same clock domain as uart_tx.

Parameters:
- ADDR_W, 4, log2 of FIFO depth; DEPTH = 2**ADDR_W = 16 bytes.
- ACK_TIMEOUT, 64, cycles to wait for uart_busy to rise after a launch before abandoning that byte.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  push strobe, one byte per cycle.
- wr_data  input  8  byte to push.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  ADDR_W+1  bytes currently stored, 0..DEPTH.
- overflow  output  1  sticky; set by a dropped push; cleared only by rst or clr_err.
- timeout_err  output  1  sticky; set by an ACK_TIMEOUT expiry; cleared only by rst or clr_err.
- clr_err  input  1  synchronous clear of both sticky flags.
- uart_busy  input  1  from uart_tx; high while a frame is shifting.
- uart_write_en  output  1  to uart_tx; single-cycle launch pulse.
- uart_data  output  8  to uart_tx; held stable from launch until the next launch.

Behaviour:
- Reset values (async assert): count=0, empty=1, full=0, overflow=0, timeout_err=0, uart_write_en=0, uart_data=8'h00, state=IDLE, rd_ptr=wr_ptr=0, timer=0.
- Reset may assert mid-frame. All stored bytes are discarded. uart_tx is reset by the same rst, so no partial-byte handshake survives.
- Storage: circular buffer with ADDR_W-bit pointers.
  - Pointers wrap modulo DEPTH (15 -> 0).
  - count is a separate ADDR_W+1 register: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- Push rule:
  - wr_en && !full: store at wr_ptr, advance wr_ptr.
  - wr_en && full: drop the byte and set overflow. This holds even if a pop occurs in the same cycle; the decision is based on registered full only.
- Drain FSM states:
  - IDLE: if !empty && !uart_busy, pop the head into uart_data, pulse uart_write_en=1 for one cycle, set timer=0, go to WAIT_BUSY.
  - WAIT_BUSY: on uart_busy==1, go to WAIT_DONE. Otherwise timer+1. When timer == ACK_TIMEOUT-1, set timeout_err and go to IDLE; the byte is lost and not retried.
  - WAIT_DONE: on uart_busy==0, go to IDLE.
- Latency: a push at edge N into an empty FIFO with the UART idle gives empty=0 after edge N. IDLE fires at edge N+1, so uart_write_en is high during cycle N+1 to N+2: one cycle after the push is registered. uart_data is valid in the same cycle.
- Back-to-back bytes: minimum gap is one IDLE cycle after busy falls. No byte is launched while uart_busy is high.
- Simultaneous events:
  - Push during pop: both happen; count unchanged.
  - clr_err in the same cycle as a new overflow or timeout event: the set wins.
- Ordering: strict FIFO. Bytes appear on uart_data in push order, excluding dropped bytes.

Optional Feature:
- Macro: UART_FIFO_CRLF_EN.
- When defined, a push of 8'h0A is stored as the two-byte sequence 8'h0D, 8'h0A, in that order.
  - It needs two free slots (count <= DEPTH-2). Otherwise both bytes are dropped and overflow is set.
  - The 0x0D is written in the push cycle. The 0x0A is written on the next cycle from an internal pending register.
  - full is forced high during the pending cycle, so the producer stalls for one cycle.
- When undefined, 8'h0A is an ordinary byte and no pending register exists.

Test Plan:
- Single byte: push 8'h41 with uart_busy=0. Expect uart_write_en pulse exactly one cycle with uart_data=8'h41 one cycle after the push. With uart_busy high for 1000 cycles, the FIFO stays empty and there are no further pulses.
- Burst: push 8 bytes, 0x30..0x37, back-to-back while the modelled uart_busy lasts 10 cycles per frame. Expect 8 pulses in order 0x30..0x37, none while busy is high, and count returns to 0.
- Full/overflow: hold uart_busy=1 and push 17 bytes. Expect full=1 and count=16 after 16 pushes; the 17th is dropped and overflow=1. Release busy: 16 bytes drain, overflow stays 1 until clr_err.
- Wrap: fill and drain 24 bytes in two interleaved bursts to cross pointer wrap. Expect output order identical to input.
- Timeout: uart_busy stuck at 0, push 8'h55. Expect one launch, then timeout_err=1 exactly 64 cycles later. Pushing 8'h56 afterwards launches normally.
- Reset mid-operation: 5 bytes queued, one in WAIT_DONE; assert rst asynchronously. Expect immediately count=0, empty=1, uart_write_en=0, uart_data=8'h00. After release, no stale bytes are sent.
- With UART_FIFO_CRLF_EN: push 8'h0A into an empty FIFO. Expect launches 8'h0D then 8'h0A. Push 8'h0A at count=15: both dropped, overflow=1.
